ycbcr2rgb_pipe: RTL and testbench

YCBCR2RGB_PIPE -- requirements
Module: ycbcr2rgb_pipe

---
 rtl/ycbcr2rgb_pipe.sv | 167 ++++++++++++++++
 tb/tb_ycbcr2rgb_pipe.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ycbcr2rgb_pipe.sv
// ycbcr2rgb_pipe -- 3-stage YCbCr (limited range) to RGB converter with
// valid/ready flow control. BT.601 or BT.709 matrix is selected per pixel.
//
// Parameters:
//   IN_W  : width of unsigned Y/Cb/Cr inputs (8..12)
//   OUT_W : width of unsigned R/G/B outputs (IN_W..IN_W+9)
// Ports:
//   iCLK, iRESET           : clock, asynchronous active-high reset
//   iY, iCb, iCr, iMODE    : input pixel and matrix select (0=BT.601, 1=BT.709)
//   iDVAL / oREADY         : input valid / block accepts input this cycle
//   oRed, oGreen, oBlue    : converted pixel
//   oDVAL / iREADY         : output valid / downstream accepts output
//   oCLIP                  : {R,G,B} saturation flags, only when the macro
//                            YCBCR2RGB_CLIP_FLAG_EN is defined
module ycbcr2rgb_pipe #(
  parameter int IN_W  = 8,
  parameter int OUT_W = 10
) (
  input  logic             iCLK,
  input  logic             iRESET,
  input  logic [IN_W-1:0]  iY,
  input  logic [IN_W-1:0]  iCb,
  input  logic [IN_W-1:0]  iCr,
  input  logic             iDVAL,
  output logic             oREADY,
  input  logic             iMODE,
  input  logic             iREADY,
  output logic [OUT_W-1:0] oRed,
  output logic [OUT_W-1:0] oGreen,
  output logic [OUT_W-1:0] oBlue,
  output logic             oDVAL
`ifdef YCBCR2RGB_CLIP_FLAG_EN
  ,
  output logic [2:0]       oCLIP
`endif
);

  // Product/sum width: (IN_W+1)-bit offset value times 13-bit coefficient,
  // plus headroom for a three-term sum and the rounding add.
  localparam int PW    = IN_W + 16;
  localparam int S     = 9 - (OUT_W - IN_W);
  localparam int RND_I = (1 << S) >> 1;

  localparam logic signed [PW-1:0]  RND   = PW'(RND_I);
  localparam logic signed [PW-1:0]  MAXV  = PW'((1 << OUT_W) - 1);
  localparam logic signed [IN_W:0]  Y_OFF = (IN_W+1)'(16 << (IN_W - 8));
  localparam logic signed [IN_W:0]  C_OFF = (IN_W+1)'(128 << (IN_W - 8));

  localparam logic signed [12:0] CY       = 13'sd596;
  localparam logic signed [12:0] CRR_601  = 13'sd817;
  localparam logic signed [12:0] CBG_601  = -13'sd200;
  localparam logic signed [12:0] CRG_601  = -13'sd416;
  localparam logic signed [12:0] CBB_601  = 13'sd1033;
  localparam logic signed [12:0] CRR_709  = 13'sd918;
  localparam logic signed [12:0] CBG_709  = -13'sd109;
  localparam logic signed [12:0] CRG_709  = -13'sd273;
  localparam logic signed [12:0] CBB_709  = 13'sd1082;

  function automatic logic [OUT_W-1:0] clamp(input logic signed [PW-1:0] v);
    if (v[PW-1])      return '0;
    else if (v > MAXV) return '1;
    else               return v[OUT_W-1:0];
  endfunction

  logic advance;

  // stage 1
  logic                 v1, mode1;
  logic signed [IN_W:0] yo1, cb1, cr1;
  logic signed [IN_W:0] yo_n, cb_n, cr_n;
  // stage 2
  logic                 v2;
  logic signed [PW-1:0] r2, g2, b2;
  logic signed [PW-1:0] r_n, g_n, b_n;
  logic signed [PW-1:0] y_x, cb_x, cr_x;
  logic signed [PW-1:0] cy_x, crr_x, cbg_x, crg_x, cbb_x;
  logic signed [12:0]   crr, cbg, crg, cbb;
  // stage 3
  logic signed [PW-1:0] r_s, g_s, b_s;
  logic [OUT_W-1:0]     red_n, green_n, blue_n;

  // Every stage moves together; a stalled output freezes the whole pipe,
  // while an empty output slot lets bubbles be squeezed out.
  assign advance = ~oDVAL | iREADY;
  assign oREADY  = advance;

  always_comb begin
    yo_n = $signed({1'b0, iY})  - Y_OFF;
    cb_n = $signed({1'b0, iCb}) - C_OFF;
    cr_n = $signed({1'b0, iCr}) - C_OFF;
  end

  always_comb begin
    crr   = mode1 ? CRR_709 : CRR_601;
    cbg   = mode1 ? CBG_709 : CBG_601;
    crg   = mode1 ? CRG_709 : CRG_601;
    cbb   = mode1 ? CBB_709 : CBB_601;
    y_x   = {{(PW-IN_W-1){yo1[IN_W]}}, yo1};
    cb_x  = {{(PW-IN_W-1){cb1[IN_W]}}, cb1};
    cr_x  = {{(PW-IN_W-1){cr1[IN_W]}}, cr1};
    cy_x  = {{(PW-13){CY[12]}},  CY};
    crr_x = {{(PW-13){crr[12]}}, crr};
    cbg_x = {{(PW-13){cbg[12]}}, cbg};
    crg_x = {{(PW-13){crg[12]}}, crg};
    cbb_x = {{(PW-13){cbb[12]}}, cbb};
    r_n   = cy_x * y_x + crr_x * cr_x;
    g_n   = cy_x * y_x + cbg_x * cb_x + crg_x * cr_x;
    b_n   = cy_x * y_x + cbb_x * cb_x;
  end

  always_comb begin
    r_s     = (r2 + RND) >>> S;
    g_s     = (g2 + RND) >>> S;
    b_s     = (b2 + RND) >>> S;
    red_n   = clamp(r_s);
    green_n = clamp(g_s);
    blue_n  = clamp(b_s);
  end

  always_ff @(posedge iCLK or posedge iRESET) begin
    if (iRESET) begin
      v1     <= 1'b0;
      mode1  <= 1'b0;
      yo1    <= '0;
      cb1    <= '0;
      cr1    <= '0;
      v2     <= 1'b0;
      r2     <= '0;
      g2     <= '0;
      b2     <= '0;
      oDVAL  <= 1'b0;
      oRed   <= '0;
      oGreen <= '0;
      oBlue  <= '0;
    end else if (advance) begin
      v1     <= iDVAL;
      mode1  <= iMODE;
      yo1    <= yo_n;
      cb1    <= cb_n;
      cr1    <= cr_n;
      v2     <= v1;
      r2     <= r_n;
      g2     <= g_n;
      b2     <= b_n;
      oDVAL  <= v2;
      oRed   <= red_n;
      oGreen <= green_n;
      oBlue  <= blue_n;
    end
  end

`ifdef YCBCR2RGB_CLIP_FLAG_EN
  logic [2:0] clip_n;

  always_comb begin
    clip_n[2] = r_s[PW-1] | (r_s > MAXV);
    clip_n[1] = g_s[PW-1] | (g_s > MAXV);
    clip_n[0] = b_s[PW-1] | (b_s > MAXV);
  end

  always_ff @(posedge iCLK or posedge iRESET) begin
    if (iRESET)       oCLIP <= '0;
    else if (advance) oCLIP <= clip_n;
  end
`endif

endmodule

// File: tb/tb_ycbcr2rgb_pipe.sv
// Self-checking bench for ycbcr2rgb_pipe (IN_W=8, OUT_W=10). A monitor pushes
// model results on every input transfer and pops/compares on every output
// transfer; scenario tasks add directed checks of latency, stall and reset.
module tb_ycbcr2rgb_pipe;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] y = '0, cb = '0, cr = '0;
  logic       dval = 1'b0;
  logic       mode = 1'b0;
  logic       rdy_in = 1'b1;
  logic       rdy_out;
  logic [9:0] red, green, blue;
  logic       odval;
`ifdef YCBCR2RGB_CLIP_FLAG_EN
  logic [2:0] clip;
`endif

  int errors = 0;
  int checks = 0;
  int out_count = 0;

  typedef struct packed {
    logic [9:0] r;
    logic [9:0] g;
    logic [9:0] b;
    logic [2:0] c;
  } exp_t;

  exp_t sb[$];

  ycbcr2rgb_pipe #(.IN_W(8), .OUT_W(10)) dut (
    .iCLK   (clk),
    .iRESET (rst),
    .iY     (y),
    .iCb    (cb),
    .iCr    (cr),
    .iDVAL  (dval),
    .oREADY (rdy_out),
    .iMODE  (mode),
    .iREADY (rdy_in),
    .oRed   (red),
    .oGreen (green),
    .oBlue  (blue),
    .oDVAL  (odval)
`ifdef YCBCR2RGB_CLIP_FLAG_EN
    ,
    .oCLIP  (clip)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int sat(input int x, output bit c);
    int v;
    v = (x + 64) >>> 7;
    c = 1'b0;
    if (v < 0) begin v = 0; c = 1'b1; end
    else if (v > 1023) begin v = 1023; c = 1'b1; end
    return v;
  endfunction

  function automatic exp_t model(input int yi, input int cbi, input int cri, input bit m);
    int yo, cbo, cro;
    int c_rr, c_bg, c_rg, c_bb;
    bit cr_f, cg_f, cb_f;
    exp_t e;
    yo  = yi - 16;
    cbo = cbi - 128;
    cro = cri - 128;
    c_rr = m ? 918 : 817;
    c_bg = m ? -109 : -200;
    c_rg = m ? -273 : -416;
    c_bb = m ? 1082 : 1033;
    e.r = 10'(sat(596 * yo + c_rr * cro, cr_f));
    e.g = 10'(sat(596 * yo + c_bg * cbo + c_rg * cro, cg_f));
    e.b = 10'(sat(596 * yo + c_bb * cbo, cb_f));
    e.c = {cr_f, cg_f, cb_f};
    return e;
  endfunction

  // Scoreboard monitor: pops on output transfer, pushes on input transfer,
  // and checks that a stalled output does not change.
  logic       prev_stall = 1'b0;
  logic [29:0] prev_rgb = '0;
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        checks++;
        if (!odval || {red, green, blue} !== prev_rgb) begin
          errors++;
          $display("FAIL hold_stable: got dval=%0b rgb=%h, required dval=1 rgb=%h",
                   odval, {red, green, blue}, prev_rgb);
        end
      end
      if (odval && rdy_in) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected: got output r=%0d g=%0d b=%0d, required no output",
                   red, green, blue);
        end else begin
          e = sb.pop_front();
          out_count++;
          if ({red, green, blue} !== {e.r, e.g, e.b}) begin
            errors++;
            $display("FAIL sb_pixel: got r=%0d g=%0d b=%0d, required r=%0d g=%0d b=%0d",
                     red, green, blue, e.r, e.g, e.b);
          end
`ifdef YCBCR2RGB_CLIP_FLAG_EN
          checks++;
          if (clip !== e.c) begin
            errors++;
            $display("FAIL sb_clip: got %b, required %b", clip, e.c);
          end
`endif
        end
      end
      prev_stall = odval && !rdy_in;
      prev_rgb   = {red, green, blue};
      if (dval && rdy_out) sb.push_back(model(int'(y), int'(cb), int'(cr), mode));
    end
  end

  task automatic test_reset();
    rst = 1'b1;
    dval = 1'b0;
    rdy_in = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (odval !== 1'b0) begin errors++; $display("FAIL reset_dval: got %b, required 0", odval); end
    checks++;
    if ({red, green, blue} !== 30'd0) begin
      errors++; $display("FAIL reset_rgb: got %h, required 0", {red, green, blue});
    end
    checks++;
    if (rdy_out !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b, required 1", rdy_out); end
`ifdef YCBCR2RGB_CLIP_FLAG_EN
    checks++;
    if (clip !== 3'b000) begin errors++; $display("FAIL reset_clip: got %b, required 000", clip); end
`endif
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_vectors();
    int ty[5]  = '{16, 235, 235, 255, 16};
    int tcb[5] = '{128, 128, 128, 128, 255};
    int tcr[5] = '{128, 128, 128, 255, 128};
    bit tm[5]  = '{0, 0, 1, 0, 0};
    int er[5]  = '{0, 1020, 1020, 1023, 0};
    int eg[5]  = '{0, 1020, 1020, 700, 0};
    int eb[5]  = '{0, 1020, 1020, 1023, 1023};
    logic [2:0] ec[5] = '{3'b000, 3'b000, 3'b000, 3'b101, 3'b011};
    int n;
    for (int i = 0; i < 5; i++) begin
      y = 8'(ty[i]); cb = 8'(tcb[i]); cr = 8'(tcr[i]); mode = tm[i];
      dval = 1'b1;
      rdy_in = 1'b1;
      @(posedge clk); #1;
      dval = 1'b0;
      n = 1;
      while (!odval && n < 10) begin
        @(posedge clk); #1;
        n++;
      end
      checks++;
      if (n !== 3) begin errors++; $display("FAIL vec%0d_latency: got %0d, required 3", i, n); end
      checks++;
      if ({red, green, blue} !== {10'(er[i]), 10'(eg[i]), 10'(eb[i])}) begin
        errors++;
        $display("FAIL vec%0d_rgb: got r=%0d g=%0d b=%0d, required r=%0d g=%0d b=%0d",
                 i, red, green, blue, er[i], eg[i], eb[i]);
      end
`ifdef YCBCR2RGB_CLIP_FLAG_EN
      checks++;
      if (clip !== ec[i]) begin errors++; $display("FAIL vec%0d_clip: got %b, required %b", i, clip, ec[i]); end
`else
      if (ec[i] === 3'bxxx) $display("unreachable");
`endif
      @(posedge clk); #1;
    end
  endtask

  task automatic test_stall();
    int py[5]  = '{50, 100, 180, 220, 81};
    int pcb[5] = '{100, 200, 90, 140, 128};
    int pcr[5] = '{150, 60, 210, 30, 128};
    bit pm[5]  = '{0, 1, 0, 1, 0};
    int sent = 0, base = out_count, stall_left = 0, cyc = 0;
    bit started = 1'b0, acc;
    logic [29:0] snap = '0;
    while ((out_count - base) < 5 && cyc < 100) begin
      if (sent < 5) begin
        y = 8'(py[sent]); cb = 8'(pcb[sent]); cr = 8'(pcr[sent]); mode = pm[sent];
        dval = 1'b1;
      end else begin
        dval = 1'b0;
      end
      rdy_in = (stall_left == 0);
      @(negedge clk);
      acc = dval && rdy_out;
      if (!rdy_in) begin
        checks++;
        if (rdy_out !== 1'b0) begin
          errors++; $display("FAIL stall_ready: got %b, required 0", rdy_out);
        end
        if (stall_left == 4) snap = {red, green, blue};
        else begin
          checks++;
          if ({red, green, blue} !== snap) begin
            errors++; $display("FAIL stall_hold: got %h, required %h", {red, green, blue}, snap);
          end
        end
      end
      @(posedge clk); #1;
      if (acc) sent++;
      if (stall_left > 0) stall_left--;
      if (!started && (out_count - base) >= 1) begin
        started = 1'b1;
        stall_left = 4;
      end
      cyc++;
    end
    dval = 1'b0;
    rdy_in = 1'b1;
    checks++;
    if ((out_count - base) !== 5 || sent !== 5) begin
      errors++; $display("FAIL stall_count: got out=%0d in=%0d, required 5 and 5", out_count - base, sent);
    end
    checks++;
    if (sb.size() !== 0) begin errors++; $display("FAIL stall_pending: got %0d, required 0", sb.size()); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 400; i++) begin
      y = 8'($urandom_range(0, 255));
      cb = 8'($urandom_range(0, 255));
      cr = 8'($urandom_range(0, 255));
      mode = 1'($urandom_range(0, 1));
      dval = ($urandom_range(0, 3) != 0);
      rdy_in = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
    end
    dval = 1'b0;
    rdy_in = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    checks++;
    if (sb.size() !== 0) begin errors++; $display("FAIL b2b_pending: got %0d, required 0", sb.size()); end
  endtask

  task automatic test_reset_midstream();
    int stale = 0, n;
    rdy_in = 1'b1;
    for (int k = 0; k < 3; k++) begin
      y = 8'(60 + 40 * k); cb = 8'(90 + k); cr = 8'(170 - k); mode = 1'(k);
      dval = 1'b1;
      @(posedge clk); #1;
    end
    dval = 1'b0;
    rst = 1'b1;
    #1;
    checks++;
    if (odval !== 1'b0) begin errors++; $display("FAIL midrst_dval: got %b, required 0", odval); end
    checks++;
    if ({red, green, blue} !== 30'd0) begin
      errors++; $display("FAIL midrst_rgb: got %h, required 0", {red, green, blue});
    end
    sb.delete();
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (odval) stale++;
      @(posedge clk); #1;
    end
    checks++;
    if (stale !== 0) begin errors++; $display("FAIL midrst_stale: got %0d, required 0", stale); end
    y = 8'd16; cb = 8'd128; cr = 8'd128; mode = 1'b0;
    dval = 1'b1;
    @(posedge clk); #1;
    dval = 1'b0;
    n = 1;
    while (!odval && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (n !== 3) begin errors++; $display("FAIL midrst_latency: got %0d, required 3", n); end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_stall();
    test_back_to_back();
    test_reset_midstream();
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (sb.size() !== 0) begin errors++; $display("FAIL final_pending: got %0d, required 0", sb.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
